reset_pulse_gen: RTL and testbench



---
 rtl/reset_pulse_pkg.sv | 15 +
 rtl/req_filter.sv | 60 ++++++
 rtl/reset_pulse_gen.sv | 153 +++++++++++++++
 tb/tb_reset_pulse_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reset_pulse_pkg.sv
// Shared definitions for the reset pulse generator: FSM state encoding and
// default timing values.
package reset_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_e;

  localparam int unsigned DEF_PULSE_W  = 16;
  localparam int unsigned DEF_GAP_W    = 8;
  localparam int unsigned DEF_FILT_LEN = 3;

endpackage

// File: rtl/req_filter.sv
// External request conditioning: 2-flop synchronizer, FILT_LEN-sample
// hysteresis filter, and a registered one-cycle event on the filtered 0->1 edge.
module req_filter
  import reset_pulse_pkg::*;
#(
  parameter int unsigned FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rstb,
  input  logic raw_i,
  output logic evt_o
);

  localparam int unsigned FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic           s1_q, s2_q;
  logic           lvl_q, lvl_d;
  logic           evt_q;
  logic [FCW-1:0] fcnt_q, fcnt_d;

  // Bring the asynchronous raw request into the clock domain.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Count consecutive samples that disagree with the level; flip on the last one.
  always_comb begin
    lvl_d  = lvl_q;
    fcnt_d = '0;
    if (s2_q != lvl_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) begin
        lvl_d = ~lvl_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter state plus a registered rising-edge event.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      lvl_q  <= 1'b0;
      fcnt_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      lvl_q  <= lvl_d;
      fcnt_q <= fcnt_d;
      evt_q  <= lvl_d & ~lvl_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/reset_pulse_gen.sv
// Reset pulse generator for the PAD reset line. Issues fixed-width active-low
// pulses on power-up, sw_req, or a filtered ext_req_raw edge, with a guaranteed
// high gap between pulses and at most one queued request.
// Optional watchdog: define RESET_WDT_EN to add wdt_kick and an idle timeout.
module reset_pulse_gen
  import reset_pulse_pkg::*;
#(
  parameter int unsigned PULSE_W     = DEF_PULSE_W,
  parameter int unsigned GAP_W       = DEF_GAP_W,
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter int unsigned CNT_W       = 8
`ifdef RESET_WDT_EN
  ,
  parameter int unsigned WDT_TIMEOUT = 200
`endif
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             sw_req,
  input  logic             ext_req_raw,
`ifdef RESET_WDT_EN
  input  logic             wdt_kick,
`endif
  output logic             pad_rstb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt,
  output state_e           dbg_state_o
);

  localparam int unsigned MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CW   = ($clog2(MAXW) > 0) ? $clog2(MAXW) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            pad_q;
  logic            first_q;
  logic [CNT_W-1:0] pcnt_q;
  logic            ext_evt;
  logic            req;
  logic            cnt_inc;

  req_filter #(.FILT_LEN(FILT_LEN)) u_ext_filter (
    .clk   (clk),
    .rstb  (rstb),
    .raw_i (ext_req_raw),
    .evt_o (ext_evt)
  );

`ifdef RESET_WDT_EN
  localparam int unsigned WW = $clog2(WDT_TIMEOUT + 1);

  logic [WW-1:0] wdt_q, wdt_d;
  logic          wdt_req;

  // Idle watchdog: counts only in IDLE, a kick in the timeout cycle suppresses the request.
  always_comb begin
    wdt_d   = '0;
    wdt_req = 1'b0;
    if (state_q == IDLE && !wdt_kick) begin
      wdt_d   = wdt_q + 1'b1;
      wdt_req = (wdt_q == WW'(WDT_TIMEOUT - 1));
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end

  assign req = sw_req | ext_evt | wdt_req;
`else
  assign req = sw_req | ext_evt;
`endif

  // Next-state logic: pulse/gap timing and the single pending request slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req || pend_q) begin
          state_d = ASSERT;
          pend_d  = 1'b0;
        end
      end
      ASSERT: begin
        if (req) pend_d = 1'b1;
        if (cnt_q == CW'(PULSE_W - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_W - 1)) begin
          cnt_d = '0;
          // A request landing on the last gap cycle is served directly.
          if (pend_q || req) begin
            state_d = ASSERT;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (req) pend_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Pulse counter steps on ASSERT entry; the power-up pulse is counted on the first edge.
  always_comb begin
    cnt_inc = first_q || (state_d == ASSERT && state_q != ASSERT);
  end

  // State, timers, registered pad output and saturating pulse count.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      pad_q   <= 1'b0;
      first_q <= 1'b1;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      pad_q   <= (state_d != ASSERT);
      first_q <= 1'b0;
      if (cnt_inc && pcnt_q != {CNT_W{1'b1}}) pcnt_q <= pcnt_q + 1'b1;
    end
  end

  assign pad_rstb    = pad_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == GAP) && (cnt_q == CW'(GAP_W - 1));
  assign pulse_cnt   = pcnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Bench for reset_pulse_gen: directed scenarios followed by randomized
// sw_req / ext_req_raw / rstb traffic, checked every cycle against a
// time-since-pulse-start reference model.
module tb_reset_pulse_gen;
  import reset_pulse_pkg::*;

  localparam int P  = 16;
  localparam int G  = 8;
  localparam int F  = 3;
  localparam int CW = 8;
  localparam int W  = CW + 3;
`ifdef RESET_WDT_EN
  localparam int WDT_TO = 200;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rstb, sw_req, ext_req_raw;
  logic          pad_rstb, busy, done;
  logic [CW-1:0] pulse_cnt;
  state_e        dbg_state;
`ifdef RESET_WDT_EN
  logic          wdt_kick;
`endif

  always #5 clk = ~clk;

  reset_pulse_gen #(
    .PULSE_W  (P),
    .GAP_W    (G),
    .FILT_LEN (F),
    .CNT_W    (CW)
`ifdef RESET_WDT_EN
    ,
    .WDT_TIMEOUT (WDT_TO)
`endif
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .sw_req      (sw_req),
    .ext_req_raw (ext_req_raw),
`ifdef RESET_WDT_EN
    .wdt_kick    (wdt_kick),
`endif
    .pad_rstb    (pad_rstb),
    .busy        (busy),
    .done        (done),
    .pulse_cnt   (pulse_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t is the number of cycles since the current pulse started; P+G means idle.
  int m_t, m_count, m_wdt;
  bit m_pend, m_fresh, m_evt, m_lvl;
  bit raw_hist[$];
  bit win[$];

  function automatic void model_reset();
    m_t = 0; m_count = 0; m_wdt = 0;
    m_pend = 0; m_fresh = 1; m_evt = 0; m_lvl = 0;
    raw_hist.delete(); repeat (2) raw_hist.push_back(1'b0);
    win.delete();      repeat (F) win.push_back(1'b0);
  endfunction

  function automatic logic [W-1:0] model_out();
    logic [CW-1:0] c;
    c = m_count[CW-1:0];
    return {(m_t >= P), (m_t < P + G), (m_t == P + G - 1), c};
  endfunction

  function automatic void bump();
    if (m_count < (1 << CW) - 1) m_count++;
  endfunction

  function automatic void model_step(input bit sw, input bit raw, input bit rb, input bit kick);
    bit idle, req, samp, all_diff;
    if (!rb) begin
      model_reset();
    end else begin
      idle = (m_t >= P + G);
      req  = sw | m_evt;
`ifdef RESET_WDT_EN
      if (idle && !kick && m_wdt == WDT_TO - 1) req = 1'b1;
      m_wdt = (idle && !kick) ? m_wdt + 1 : 0;
`else
      if (kick) req = req;
`endif
      if (m_fresh) begin bump(); m_fresh = 0; end
      if (idle) begin
        if (req) begin m_t = 0; bump(); end
      end else if (m_t == P + G - 1) begin
        if (m_pend || req) begin m_t = 0; m_pend = 0; bump(); end
        else m_t = P + G;
      end else begin
        if (req) m_pend = 1;
        m_t++;
      end
      // external path: two-cycle delay, then flip after F disagreeing samples
      raw_hist.push_back(raw);
      samp = raw_hist.pop_front();
      win.push_back(samp);
      void'(win.pop_front());
      all_diff = 1;
      foreach (win[i]) if (win[i] == m_lvl) all_diff = 0;
      m_evt = 0;
      if (all_diff) begin m_lvl = !m_lvl; m_evt = m_lvl; end
    end
    exp_q.push_back(model_out());
  endfunction

  // ---------------- driver ----------------
  task automatic tick(input bit sw, input bit raw, input bit rb);
    logic [W-1:0] e;
    bit kick;
    @(negedge clk);
    e = exp_q.pop_front();
    chk("pad_rstb",  {31'd0, pad_rstb}, {31'd0, e[W-1]});
    chk("busy",      {31'd0, busy},     {31'd0, e[W-2]});
    chk("done",      {31'd0, done},     {31'd0, e[W-3]});
    chk("pulse_cnt", {24'd0, pulse_cnt}, {24'd0, e[CW-1:0]});
    kick = ($urandom_range(0, 179) == 0);
    sw_req      = sw;
    ext_req_raw = raw;
    rstb        = rb;
`ifdef RESET_WDT_EN
    wdt_kick    = kick;
`endif
    model_step(sw, raw, rb, kick);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit sw, raw_lvl, rb;
    int run_len, rst_len;
    rstb = 1'b0; sw_req = 1'b0; ext_req_raw = 1'b0;
`ifdef RESET_WDT_EN
    wdt_kick = 1'b0;
`endif
    model_reset();
    exp_q.push_back(model_out());

    // power-up pulse
    repeat (3)  tick(0, 0, 0);
    repeat (40) tick(0, 0, 1);
    // single software request
    tick(1, 0, 1);
    repeat (35) tick(0, 0, 1);
    // 2-cycle glitch, then a clean 10-cycle request
    repeat (2)  tick(0, 1, 1);
    repeat (20) tick(0, 0, 1);
    repeat (10) tick(0, 1, 1);
    repeat (35) tick(0, 0, 1);
    // high with a one-cycle dropout
    repeat (6)  tick(0, 1, 1);
    tick(0, 0, 1);
    repeat (6)  tick(0, 1, 1);
    repeat (35) tick(0, 0, 1);
    // requests during ASSERT and GAP collapse into one queued pulse
    tick(1, 0, 1);
    repeat (4)  tick(0, 0, 1);
    tick(1, 0, 1);
    repeat (11) tick(0, 0, 1);
    tick(1, 1, 1);
    repeat (6)  tick(0, 1, 1);
    repeat (45) tick(0, 0, 1);
    // reset in the middle of a pulse with a request pending
    tick(1, 0, 1);
    repeat (7)  tick(0, 0, 1);
    tick(1, 0, 1);
    repeat (2)  tick(0, 0, 0);
    repeat (40) tick(0, 0, 1);

    // randomized traffic
    run_len = 0; rst_len = 0; raw_lvl = 0;
    for (int i = 0; i < 2000; i++) begin
      sw = ($urandom_range(0, 39) == 0);
      if (run_len == 0) begin
        raw_lvl = $urandom_range(0, 1);
        run_len = $urandom_range(1, 12);
      end
      run_len--;
      if (rst_len == 0 && $urandom_range(0, 399) == 0) rst_len = $urandom_range(1, 3);
      rb = (rst_len == 0);
      if (rst_len > 0) rst_len--;
      tick(sw, raw_lvl, rb);
    end
    repeat (30) tick(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
